// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV  = 2'b00,
      DIVU = 2'b01,
      REM  = 2'b10,
      REMU = 2'b11
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIN  = 2'b10
   } div_state_e;

   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] DIV_OVF_Q  = 32'h8000_0000;

   function automatic logic op_is_signed(div_op_e op);
      return (op == DIV) || (op == REM);
   endfunction

   function automatic logic op_is_rem(div_op_e op);
      return (op == REM) || (op == REMU);
   endfunction

endpackage

// File: rtl/div_unit_if.sv
// Launch/result handshake between the EX stage and the divider.
interface div_unit_if
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
);
   logic            start;
   div_op_e         op;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            kill;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, op, src1, src2, kill,
      input  busy, done, result
   );

   modport slave (
      input  start, op, src1, src2, kill,
      output busy, done, result
   );
endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] quo_in,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_out,
   output logic [XLEN-1:0] quo_out
);
   logic [XLEN:0]   shifted;
   logic [XLEN-1:0] diff;
   logic            ge;

   // The partial remainder stays below the divisor, so once ge holds the
   // difference always fits in XLEN bits and the top bit can be dropped.
   always_comb begin
      shifted = {rem_in, quo_in[XLEN-1]};
      ge      = shifted >= {1'b0, divisor};
      diff    = shifted[XLEN-1:0] - divisor;
      rem_out = ge ? diff : shifted[XLEN-1:0];
      quo_out = {quo_in[XLEN-2:0], ge};
   end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, 32 steps
// FIN   | signed result registered, done high for this cycle
module div_unit
   import div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);
   localparam int CNT_W = $clog2(XLEN);

   div_state_e       state;
   div_op_e          op_q;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  rem_q;
   logic [XLEN-1:0]  quo_q;
   logic [XLEN-1:0]  divisor_q;
   logic             q_neg;
   logic             r_neg;
   logic             busy_q;
   logic             done_q;
   logic [XLEN-1:0]  result_q;

   logic [XLEN-1:0]  rem_nxt;
   logic [XLEN-1:0]  quo_nxt;
   logic [XLEN-1:0]  fin_val;
   logic             sgn;
   logic             ovf;
   logic [XLEN-1:0]  abs1;
   logic [XLEN-1:0]  abs2;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_in  (rem_q),
      .quo_in  (quo_q),
      .divisor (divisor_q),
      .rem_out (rem_nxt),
      .quo_out (quo_nxt)
   );

   always_comb begin
      sgn     = op_is_signed(bus.op);
      ovf     = sgn && (bus.src1 == DIV_OVF_Q) && (bus.src2 == DIV_ZERO_Q);
      abs1    = (sgn && bus.src1[XLEN-1]) ? -bus.src1 : bus.src1;
      abs2    = (sgn && bus.src2[XLEN-1]) ? -bus.src2 : bus.src2;
      fin_val = op_is_rem(op_q) ? (r_neg ? -rem_nxt : rem_nxt)
                                : (q_neg ? -quo_nxt : quo_nxt);
   end

   // Result is registered on the edge into FIN so it is valid with done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         op_q      <= DIV;
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         divisor_q <= '0;
         q_neg     <= 1'b0;
         r_neg     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start && !bus.kill) begin
                  op_q   <= bus.op;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  if (bus.src2 == '0) begin
                     state    <= FIN;
                     done_q   <= 1'b1;
                     result_q <= op_is_rem(bus.op) ? bus.src1 : DIV_ZERO_Q;
                  end else if (ovf) begin
                     state    <= FIN;
                     done_q   <= 1'b1;
                     result_q <= op_is_rem(bus.op) ? '0 : DIV_OVF_Q;
                  end else begin
                     state     <= CALC;
                     rem_q     <= '0;
                     quo_q     <= abs1;
                     divisor_q <= abs2;
                     q_neg     <= sgn && (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
                     r_neg     <= sgn && bus.src1[XLEN-1];
                  end
               end
            end
            CALC: begin
               if (bus.kill) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  rem_q <= rem_nxt;
                  quo_q <= quo_nxt;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(XLEN - 1)) begin
                     state    <= FIN;
                     done_q   <= 1'b1;
                     result_q <= fin_val;
                  end
               end
            end
            FIN: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed checks of div_unit against an arithmetic reference.
module tb_div_unit;
   import div_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] last_exp = 32'd0;

   div_unit_if #(.XLEN(32)) bus ();

   div_unit #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic is_special(div_op_e op, logic [31:0] a, logic [31:0] b);
      return (b == 32'd0) ||
             ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_div(div_op_e op, logic [31:0] a, logic [31:0] b);
      if (b == 32'd0)
         return (op == REM || op == REMU) ? a : 32'hFFFF_FFFF;
      if ((op == DIV || op == REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return (op == REM) ? 32'd0 : 32'h8000_0000;
      case (op)
         DIV:     return 32'($signed(a) / $signed(b));
         DIVU:    return a / b;
         REM:     return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   // poke > 0 pulses a stray start during that cycle of the operation.
   task automatic run_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input int poke, input string tag);
      logic [31:0] exp;
      logic [31:0] got;
      int          lat;
      int          bc;
      int          exp_lat;
      exp     = ref_div(op, a, b);
      exp_lat = is_special(op, a, b) ? 1 : 33;
      lat = 0;
      bc  = 0;
      got = 32'd0;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src1  = a;
      bus.src2  = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.src1  = $urandom;
      bus.src2  = $urandom;
      for (int c = 1; c <= 40; c++) begin
         if (c > 1) @(negedge clk);
         if (bus.busy) bc++;
         if (bus.start) bus.start = 1'b0;
         if (c == poke) begin
            bus.start = 1'b1;
            bus.op    = div_op_e'(2'($urandom_range(0, 3)));
            bus.src1  = $urandom;
            bus.src2  = $urandom_range(1, 100);
         end
         if (bus.done) begin
            lat = c;
            got = bus.result;
            @(negedge clk);
            bus.start = 1'b0;
            check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
            break;
         end
      end
      check({tag, "_result"}, got, exp);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_lat));
      last_exp = exp;
   endtask

   initial begin
      int dones;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      bus.op    = DIV;
      bus.src1  = 32'd0;
      bus.src2  = 32'd0;
      #3;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(DIVU, 32'd100, 32'd7, 0, "divu_100_7");
      run_op(REMU, 32'd100, 32'd7, 0, "remu_100_7");
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2");
      run_op(REM, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2");
      run_op(DIV, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2");
      run_op(DIV, 32'd5, 32'd0, 0, "div_by_zero");
      run_op(REMU, 32'h1234_5678, 32'd0, 0, "remu_by_zero");
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");
      run_op(DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, "divu_big");
      run_op(REM, 32'd0, 32'hFFFF_FFF3, 0, "rem_zero_dividend");
      run_op(DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "div_m1_poke_fin");

      // Flush during CALC: no done, result holds the previous value.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = DIVU;
      bus.src1  = 32'd1000;
      bus.src2  = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (9) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill_busy", 32'(bus.busy), 32'd0);
      dones = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      check("kill_no_done", 32'(dones), 32'd0);
      check("kill_result_held", bus.result, last_exp);
      run_op(DIVU, 32'd9, 32'd3, 0, "divu_after_kill");

      // Kill beats a simultaneous start in IDLE.
      @(negedge clk);
      bus.start = 1'b1;
      bus.kill  = 1'b1;
      bus.op    = DIVU;
      bus.src1  = 32'd50;
      bus.src2  = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      bus.kill  = 1'b0;
      check("kill_start_busy", 32'(bus.busy), 32'd0);
      check("kill_start_done", 32'(bus.done), 32'd0);

      run_op(DIVU, 32'd77, 32'd6, 5, "poke_mid_calc");

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = DIV;
      bus.src1  = 32'hFFFF_0000;
      bus.src2  = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_done", 32'(bus.done), 32'd0);
      check("arst_result", bus.result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_exp = 32'd0;

      for (int i = 0; i < 40; i++) begin
         div_op_e     op;
         logic [31:0] a;
         logic [31:0] b;
         int          mode;
         op   = div_op_e'(2'($urandom_range(0, 3)));
         mode = $urandom_range(0, 7);
         a    = $urandom;
         b    = $urandom;
         case (mode)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin
               a = 32'($urandom_range(0, 400)) - 32'd200;
               b = 32'($urandom_range(0, 40)) - 32'd20;
            end
            3: a = 32'd0;
            4: b = 32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op(op, a, b, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 33) : 0, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
